// File: rtl/alu_result_stage.sv
// ALU result stage: buffers ALU results with flags, commits flags on pop and
// decodes branch conditions. ALU_RESULT_SKID_EN selects a 2-entry skid buffer.
module alu_result_stage (
  input  logic        input_CLK,
  input  logic        input_Reset_n,
  input  logic [15:0] input_Result,
  input  logic        input_Zero,
  input  logic        input_Negative,
  input  logic        input_Carry,
  input  logic        input_Valid,
  output logic        output_Ready,
  output logic [15:0] output_ALUOut,
  output logic        output_Valid,
  input  logic        input_Ready,
  input  logic        input_FlagWrite,
  input  logic [2:0]  input_BranchCond,
  output logic        output_FlagZ,
  output logic        output_FlagN,
  output logic        output_FlagC,
  output logic        output_BranchTaken,
  output logic [1:0]  output_Count
);

  typedef struct packed {
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        c;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state_q;
  entry_t in_e, head_e;
  logic   push, pop;
  logic   fz_q, fn_q, fc_q;

  assign in_e   = {input_Result, input_Zero, input_Negative, input_Carry};
  assign push   = input_Valid && output_Ready;
  assign pop    = output_Valid && input_Ready;

  assign output_Valid  = (state_q != EMPTY);
  assign output_ALUOut = output_Valid ? head_e.res : 16'h0000;
  assign output_Count  = (state_q == FULL) ? 2'd2 :
                         (state_q == ONE)  ? 2'd1 : 2'd0;

`ifdef ALU_RESULT_SKID_EN
  entry_t mem_q [2];
  logic   wr_ptr_q, rd_ptr_q;

  assign head_e       = mem_q[rd_ptr_q];
  // Ready comes from state alone, so upstream never sees a path from input_Ready.
  assign output_Ready = (state_q != FULL);

  always_ff @(posedge input_CLK or negedge input_Reset_n) begin
    if (!input_Reset_n) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_e;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case (state_q)
        EMPTY: if (push) state_q <= ONE;
        ONE: begin
          if (push && !pop)      state_q <= FULL;
          else if (pop && !push) state_q <= EMPTY;
        end
        FULL:    if (pop) state_q <= ONE;
        default: state_q <= EMPTY;
      endcase
    end
  end
`else
  entry_t data_q;

  assign head_e       = data_q;
  // Single register: a pop frees the slot for a push in the same cycle.
  assign output_Ready = !output_Valid || input_Ready;

  always_ff @(posedge input_CLK or negedge input_Reset_n) begin
    if (!input_Reset_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      if (push) data_q <= in_e;
      case (state_q)
        EMPTY:   if (push) state_q <= ONE;
        ONE:     if (pop && !push) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end
`endif

  always_ff @(posedge input_CLK or negedge input_Reset_n) begin
    if (!input_Reset_n) begin
      fz_q <= 1'b0;
      fn_q <= 1'b0;
      fc_q <= 1'b0;
    end else if (pop && input_FlagWrite) begin
      fz_q <= head_e.z;
      fn_q <= head_e.n;
      fc_q <= head_e.c;
    end
  end

  assign output_FlagZ = fz_q;
  assign output_FlagN = fn_q;
  assign output_FlagC = fc_q;

  always_comb begin
    output_BranchTaken = 1'b0;
    case (input_BranchCond)
      3'b000: output_BranchTaken = 1'b0;
      3'b001: output_BranchTaken = 1'b1;
      3'b010: output_BranchTaken = fz_q;
      3'b011: output_BranchTaken = !fz_q;
      3'b100: output_BranchTaken = fn_q;
      3'b101: output_BranchTaken = !fn_q;
      3'b110: output_BranchTaken = fc_q;
      3'b111: output_BranchTaken = !fc_q;
      default: output_BranchTaken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed steps plus random traffic checked
// against a queue-based model of the result buffer and flag register.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] res;
  logic        z, n, c, vld_in, rdy_in, fw;
  logic [2:0]  bc;
  logic        rdy_out, vld_out, fz, fn, fc, taken;
  logic [15:0] aluout;
  logic [1:0]  cnt;

  int passes = 0;
  int total  = 0;

  logic [18:0] mq[$];
  logic [2:0]  mflags;

`ifdef ALU_RESULT_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  alu_result_stage dut (
    .input_CLK(clk), .input_Reset_n(rst_n), .input_Result(res),
    .input_Zero(z), .input_Negative(n), .input_Carry(c), .input_Valid(vld_in),
    .output_Ready(rdy_out), .output_ALUOut(aluout), .output_Valid(vld_out),
    .input_Ready(rdy_in), .input_FlagWrite(fw), .input_BranchCond(bc),
    .output_FlagZ(fz), .output_FlagN(fn), .output_FlagC(fc),
    .output_BranchTaken(taken), .output_Count(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic br(input logic [2:0] cond, input logic [2:0] f);
    logic [7:0] tbl;
    tbl = {~f[0], f[0], ~f[1], f[1], ~f[2], f[2], 1'b1, 1'b0};
    return tbl[cond];
  endfunction

  function automatic logic model_ready(input logic r);
    if (CAP == 2) return mq.size() < 2;
    return (mq.size() == 0) || r;
  endfunction

  task automatic check_outs();
    chk("valid",  vld_out, mq.size() != 0);
    chk("aluout", aluout,  (mq.size() != 0) ? mq[0][18:3] : 16'h0000);
    chk("count",  cnt,     mq.size());
    chk("flags",  {fz, fn, fc}, mflags);
    chk("branch", taken,   br(bc, mflags));
  endtask

  // Called at a falling edge: drive, check ready, clock, update model, check.
  task automatic cycle(input logic v, input logic [15:0] r, input logic [2:0] znc,
                       input logic rd, input logic f, input logic [2:0] cond);
    logic push, pop;
    logic [18:0] popped;
    vld_in = v; res = r; {z, n, c} = znc; rdy_in = rd; fw = f; bc = cond;
    #1;
    chk("ready", rdy_out, model_ready(rd));
    push = v && model_ready(rd);
    pop  = (mq.size() != 0) && rd;
    @(posedge clk);
    if (pop) begin
      popped = mq.pop_front();
      if (f) mflags = popped[2:0];
    end
    if (push) mq.push_back({r, znc});
    if (mq.size() > CAP) chk("model_cap", mq.size(), CAP);
    @(negedge clk);
    check_outs();
  endtask

  task automatic reset_midop();
    bc = 3'b110;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", vld_out, 1'b0);
    chk("rst_aluout", aluout, 16'h0000);
    chk("rst_ready", rdy_out, 1'b1);
    chk("rst_count", cnt, 2'd0);
    chk("rst_flags", {fz, fn, fc}, 3'b000);
    chk("rst_branch_c", taken, 1'b0);
    mq.delete();
    mflags = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; res = '0; {z, n, c} = 3'b000; vld_in = 0; rdy_in = 0; fw = 0; bc = 3'b000;
    mflags = 3'b000;
    #2;
    chk("init_valid", vld_out, 1'b0);
    chk("init_aluout", aluout, 16'h0000);
    chk("init_ready", rdy_out, 1'b1);
    chk("init_count", cnt, 2'd0);
    chk("init_flags", {fz, fn, fc}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    cycle(1, 16'h1234, 3'b001, 0, 0, 3'b001);
    chk("first_push_out", aluout, 16'h1234);
    cycle(0, 16'h0000, 3'b000, 1, 0, 3'b000);

    cycle(1, 16'h0001, 3'b000, 0, 0, 3'b000);
    cycle(1, 16'h0002, 3'b000, 0, 0, 3'b000);
    cycle(1, 16'h0003, 3'b000, 0, 0, 3'b000);
    cycle(0, 16'h0000, 3'b000, 1, 0, 3'b000);
    cycle(0, 16'h0000, 3'b000, 1, 0, 3'b000);
    cycle(0, 16'h0000, 3'b000, 1, 0, 3'b000);

    cycle(1, 16'hAAAA, 3'b000, 0, 0, 3'b000);
    cycle(1, 16'h5555, 3'b000, 1, 0, 3'b000);
    chk("pushpop_head", aluout, 16'h5555);
    chk("pushpop_count", cnt, 2'd1);
    cycle(0, 16'h0000, 3'b000, 1, 0, 3'b000);

    cycle(1, 16'hAAAA, 3'b100, 0, 0, 3'b010);
    cycle(0, 16'h0000, 3'b000, 1, 1, 3'b010);
    chk("flagz_set", fz, 1'b1);
    chk("bc010_taken", taken, 1'b1);
    cycle(0, 16'h0000, 3'b000, 0, 0, 3'b011);
    chk("bc011_taken", taken, 1'b0);
    cycle(1, 16'h0F0F, 3'b011, 0, 0, 3'b000);
    cycle(0, 16'h0000, 3'b000, 1, 0, 3'b000);
    chk("fw0_hold", {fz, fn, fc}, 3'b100);

    cycle(1, 16'h7777, 3'b111, 0, 0, 3'b110);
    cycle(0, 16'h0000, 3'b000, 1, 1, 3'b110);
    cycle(1, 16'h1111, 3'b000, 0, 0, 3'b110);
    cycle(1, 16'h2222, 3'b000, 0, 0, 3'b110);
    reset_midop();
    cycle(1, 16'hBEEF, 3'b010, 0, 0, 3'b000);
    chk("post_rst_push", aluout, 16'hBEEF);
    cycle(0, 16'h0000, 3'b000, 1, 1, 3'b010);

    for (int i = 0; i < 20; i++) cycle(1, 16'(i * 16'h0101), 3'(i), 1, 1, 3'(i));

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 16'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom));
      if (i == 200) reset_midop();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 input_CLK  input  1  single clock; all state updates on rising edge.
REQ-002 input_Reset_n  input  1  asynchronous, active-low reset.
REQ-003 input_Result  input  16  ALU result word from the ALU stage.
REQ-004 input_Zero, input_Negative, input_Carry  input  1 each  ALU flags accompanying input_Result.
REQ-005 input_Valid  input  1  upstream asserts: result and flags are valid this cycle.
REQ-006 output_Ready  output  1  stage can accept an entry this cycle.
REQ-007 output_ALUOut  output  16  head-entry result (ALUOut register) for the register-file/memory stage.
REQ-008 output_Valid  output  1  output_ALUOut holds a valid entry.
REQ-009 input_Ready  input  1  downstream consumes the head entry this cycle.
REQ-010 input_FlagWrite  input  1  on a pop, commit the popped entry's flags to the flag register.
REQ-011 input_BranchCond  input  3  branch condition selector.
REQ-012 output_FlagZ, output_FlagN, output_FlagC  output  1 each  committed flag register.
REQ-013 output_BranchTaken  output  1  branch decision from the committed flags.
REQ-014 output_Count  output  2  number of buffered entries (0..2).

Function
REQ-015 Buffer entry = {result[15:0], Z, N, C}; strict FIFO order.
REQ-016 Push = input_Valid && output_Ready; pop = output_Valid && input_Ready.
REQ-017 State machine: EMPTY (count 0), ONE (count 1), FULL (count 2).
REQ-018 Transitions: EMPTY -push-> ONE; ONE -push only-> FULL; ONE -pop only-> EMPTY; ONE -push and pop-> ONE; FULL -pop-> ONE; otherwise hold.
REQ-019 output_Ready = 1 in EMPTY and ONE, 0 in FULL. It is registered state only and does not depend on input_Ready.
REQ-020 input_Valid while in FULL is ignored; no entry is overwritten or dropped.
REQ-021 Latency: an entry pushed at edge N appears on output_ALUOut/output_Valid after edge N; minimum one cycle, no combinational input-to-output path.
REQ-022 output_Valid = (count != 0). output_ALUOut = head result when valid, 16'h0000 when EMPTY.
REQ-023 Simultaneous push and pop in ONE: the pushed entry becomes head after the edge.
REQ-024 input_Ready while EMPTY has no effect.
REQ-025 Flag register: on a pop with input_FlagWrite=1, load the popped entry's Z/N/C at that edge; otherwise hold.
REQ-026 input_FlagWrite without a pop has no effect.
REQ-027 BranchCond decode (combinational from the flag register):
- 000 never; 001 always
- 010 Z; 011 !Z
- 100 N; 101 !N
- 110 C; 111 !C
REQ-028 Read and write pointers are 1-bit and wrap 1->0.

Reset
REQ-029 input_Reset_n low, asynchronously and regardless of the clock:
- count=0, pointers=0, state EMPTY
- output_Valid=0, output_ALUOut=16'h0000, output_Ready=1
- flag register=000
REQ-030 Reset mid-operation discards all buffered entries. The first push after deassertion is accepted on the next rising edge.

Configuration
REQ-031 Macro ALU_RESULT_SKID_EN defined: 2-entry buffer exactly as specified above.
REQ-032 Macro ALU_RESULT_SKID_EN undefined: single-entry register.
- State FULL does not exist; output_Count is at most 1.
- output_Ready = !output_Valid || input_Ready (combinational pass-through).
- All other requirements unchanged.

Verification
REQ-033 Reset, then push 16'h1234 with Z=0 N=0 C=1 -> next cycle output_Valid=1, output_ALUOut=16'h1234, output_Count=1.
REQ-034 input_Ready=0, push 16'h0001 then 16'h0002 -> output_Count=2, output_Ready=0; pushing 16'h0003 is ignored; popping yields 0001, then 0002.
REQ-035 Count=1 (head 16'hAAAA), simultaneous push 16'h5555 and pop -> count stays 1, output_ALUOut=16'h5555.
REQ-036 Pop an entry with Z=1 N=0 C=0 and FlagWrite=1 -> FlagZ=1; BranchCond 010 gives BranchTaken=1, 011 gives 0; a pop with FlagWrite=0 leaves the flags unchanged.
REQ-037 FULL with flags=111, assert input_Reset_n=0 between clock edges -> outputs reach reset values immediately; count=0; BranchCond 110 gives 0.
REQ-038 ALU_RESULT_SKID_EN undefined, continuous push every cycle with input_Ready=1 -> one result per cycle, output_Ready stays 1, output_Count never exceeds 1.
